execute_stage: RTL and testbench
================================

# execute_stage

Y86-64 pipeline execute stage: consumes the decode-to-execute register fields, selects ALU operands, computes valE with the 64-bit ALU (add/sub/and/xor), maintains the condition-code register and evaluates branch/cmov conditions. It holds the execute-to-memory pipeline register and feeds the memory stage. Stall and bubble controls come from pipeline control logic.

## Interface
- Parameters: W, 64, data width; REG_NONE, 4'hF, "no register" ID
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- E_stat  in  4  status (AOK=1, HLT=2, ADR=3, INS=4)
- E_icode, E_ifun  in  4 each  instruction code and function
- E_valC, E_valA, E_valB  in  W each  constant and register operands
- E_dstE, E_dstM  in  4 each  destination register IDs
- m_stat, W_stat  in  4 each  status in memory/writeback; any non-AOK value blocks CC update
- M_stall  in  1  hold M register
- M_bubble  in  1  load NOP bubble into M register
- M_stat, M_icode  out  4 each  registered
- M_Cnd  out  1  registered condition result
- M_valE, M_valA  out  W each  registered
- M_dstE, M_dstM  out  4 each  registered
- cc_zf, cc_sf, cc_of  out  1 each  current condition codes

## Operation
- aluA: valA for RRMOVQ(2)/OPQ(6); valC for IRMOVQ(3)/RMMOVQ(4)/MRMOVQ(5); -8 for CALL(8)/PUSHQ(A); +8 for RET(9)/POPQ(B); else 0.
- aluB: valB for RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ; 0 otherwise.
- alufun = E_ifun when icode=OPQ, else ADD. ADD(0): B+A; SUB(1): B−A; AND(2): B&A; XOR(3): B^A. Wrap modulo 2^64, no saturation. ifun>3 on OPQ yields 0 with no CC update.
- Flags: ZF = result==0; SF = result[63]; OF on ADD = A,B same sign and result sign differs; OF on SUB = A,B differ in sign and result sign differs from B; OF=0 for AND/XOR.
- set_cc = (icode==OPQ) && ifun≤3 && m_stat==AOK && W_stat==AOK && !rst.
- Cnd from current CC: ifun 0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=!ZF; 5 ge=!(SF^OF); 6 g=!(SF^OF)&!ZF; ≥7 gives 0. Evaluated only for RRMOVQ and JXX(7); 1 for all other icodes.
- e_dstE = REG_NONE when icode=RRMOVQ and Cnd=0, else E_dstE.
- M register loads {E_stat, E_icode, Cnd, valE, E_valA, e_dstE, E_dstM}.

## Timing
- Reset (synchronous): CC = ZF1/SF0/OF0; M register = bubble: stat AOK, icode NOP(1), Cnd 0, valE 0, valA 0, dstE/dstM REG_NONE.
- Latency: one cycle, E inputs to M outputs. CC updates at the same edge; Cnd uses the pre-update CC, so an OPQ followed by JXX sees the OPQ's flags.
- Priority per edge: rst > M_stall (hold M; CC still updates if set_cc) > M_bubble (load bubble) > normal load.
- M_stall and M_bubble together: stall wins.
- Reset asserted mid-stream discards the in-flight instruction; no CC update that edge.
- Exception in m_stat/W_stat: CC frozen for that cycle; M register still loads normally.

## Configuration
- EXEC_FWD_EN defined: adds combinational outputs e_valE (W) and e_dstE (4) for decode forwarding, valid in the same cycle as E inputs.
- Undefined: ports absent; forwarding uses only registered M outputs.

## Structure
- Shared package y86_pkg: icode, alufun, condition, stat encodings, REG_NONE, W.
- Sub-module alu64: combinational, (A, B, fun) → (result, zf, sf, of). Operand mux, CC register, cond logic and M register stay in execute_stage.

## Test plan
- OPQ ADD with A=0x7FFF_FFFF_FFFF_FFFF, B=1 → M_valE=0x8000_0000_0000_0000; next cycle ZF0 SF1 OF1.
- OPQ SUB with A=5, B=5 → valE 0, ZF1 SF0 OF0; the following JXX ifun=3 (e) gives M_Cnd=1 and ifun=4 gives 0.
- OPQ AND with A=0xFFFF_0000, B=0x0F0F_0F0F → valE 0x0F0F_0000, OF0; with W_stat=ADR, CC stays unchanged.
- CMOVXX ifun=2 (l) with SF=OF=0, dstE=3 → M_dstE=0xF, valE=valA; PUSHQ with valB=0x100 → valE 0xF8.
- M_stall held 2 cycles → M outputs constant; M_bubble → icode NOP, dstE/dstM 0xF; both asserted → hold.
- rst asserted mid-stream → next edge: ZF1 SF0 OF0, M icode NOP, stat AOK, valE 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, branch/cmov
// conditions, status codes, data width and the "no register" ID.
package y86_pkg;

  localparam int         W        = 64;
  localparam logic [3:0] REG_NONE = 4'hF;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions
  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  // Branch / conditional-move conditions
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Status codes
  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  // Condition evaluation against a set of flags; unknown conditions are false.
  function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                     input logic sf, input logic of);
    case (fn)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu64.sv
// Combinational Y86-64 ALU: add/sub/and/xor with zero/sign/overflow flags.
// Unsupported function codes produce a zero result and no overflow.
module alu64 import y86_pkg::*; #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_fun,
  output logic [W-1:0] o_result,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of
);

  logic [W-1:0] w_res;
  logic         w_of;

  // Result and signed overflow; subtraction is B - A
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (i_fun)
      A_ADD: begin
        w_res = i_b + i_a;
        w_of  = (i_a[W-1] == i_b[W-1]) && (w_res[W-1] != i_a[W-1]);
      end
      A_SUB: begin
        w_res = i_b - i_a;
        w_of  = (i_a[W-1] != i_b[W-1]) && (w_res[W-1] != i_b[W-1]);
      end
      A_AND:   w_res = i_b & i_a;
      A_XOR:   w_res = i_b ^ i_a;
      default: w_res = '0;
    endcase
  end

  assign o_result = w_res;
  assign o_zf     = (w_res == '0);
  assign o_sf     = w_res[W-1];
  assign o_of     = w_of;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes, branch/cmov
// condition, and the execute-to-memory (M) pipeline register.
// Optional feature macro EXEC_FWD_EN: exposes combinational e_valE/e_dstE
// for decode-stage forwarding.
module execute_stage import y86_pkg::*; #(
  parameter int         W        = y86_pkg::W,
  parameter logic [3:0] REG_NONE = y86_pkg::REG_NONE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valC,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [3:0]   m_stat,
  input  logic [3:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic [3:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
`ifdef EXEC_FWD_EN
  ,output logic [W-1:0] e_valE
  ,output logic [3:0]   e_dstE
`endif
);

  logic [W-1:0] w_aluA, w_aluB, w_valE;
  logic [3:0]   w_alufun, w_dstE;
  logic         w_zf, w_sf, w_of, w_set_cc, w_cnd;

  logic         r_zf, r_sf, r_of;
  logic [3:0]   r_stat, r_icode, r_dstE, r_dstM;
  logic         r_cnd;
  logic [W-1:0] r_valE, r_valA;

  // ALU operand and function selection by instruction class
  always_comb begin
    w_aluA = '0;
    w_aluB = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:              w_aluA = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_aluA = E_valC;
      I_CALL, I_PUSHQ:              w_aluA = -W'(8);
      I_RET, I_POPQ:                w_aluA = W'(8);
      default:                      w_aluA = '0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
      I_PUSHQ, I_RET, I_POPQ:       w_aluB = E_valB;
      default:                      w_aluB = '0;
    endcase
    w_alufun = (E_icode == I_OPQ) ? E_ifun : A_ADD;
  end

  alu64 #(.W(W)) u_alu (
    .i_a      (w_aluA),
    .i_b      (w_aluB),
    .i_fun    (w_alufun),
    .o_result (w_valE),
    .o_zf     (w_zf),
    .o_sf     (w_sf),
    .o_of     (w_of)
  );

  // Only valid arithmetic ops update flags, and only while nothing downstream
  // has faulted.
  assign w_set_cc = (E_icode == I_OPQ) && (E_ifun <= A_XOR) &&
                    (m_stat == S_AOK) && (W_stat == S_AOK) && !rst;

  // Condition uses the flags from before this edge's update
  always_comb begin
    w_cnd  = 1'b1;
    if (E_icode == I_RRMOVQ || E_icode == I_JXX)
      w_cnd = cond_eval(E_ifun, r_zf, r_sf, r_of);
    w_dstE = (E_icode == I_RRMOVQ && !w_cnd) ? REG_NONE : E_dstE;
  end

  // Condition-code register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= w_zf;
      r_sf <= w_sf;
      r_of <= w_of;
    end
  end

  // M pipeline register: reset > stall > bubble > load
  always_ff @(posedge clk) begin
    if (rst || (!M_stall && M_bubble)) begin
      r_stat  <= S_AOK;
      r_icode <= I_NOP;
      r_cnd   <= 1'b0;
      r_valE  <= '0;
      r_valA  <= '0;
      r_dstE  <= REG_NONE;
      r_dstM  <= REG_NONE;
    end else if (!M_stall) begin
      r_stat  <= E_stat;
      r_icode <= E_icode;
      r_cnd   <= w_cnd;
      r_valE  <= w_valE;
      r_valA  <= E_valA;
      r_dstE  <= w_dstE;
      r_dstM  <= E_dstM;
    end
  end

  assign M_stat  = r_stat;
  assign M_icode = r_icode;
  assign M_Cnd   = r_cnd;
  assign M_valE  = r_valE;
  assign M_valA  = r_valA;
  assign M_dstE  = r_dstE;
  assign M_dstM  = r_dstM;
  assign cc_zf   = r_zf;
  assign cc_sf   = r_sf;
  assign cc_of   = r_of;

`ifdef EXEC_FWD_EN
  assign e_valE = w_valE;
  assign e_dstE = w_dstE;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: each step drives one E-stage instruction,
// a reference model pushes the expected M register / CC state to a queue,
// and the entry is popped and compared one edge later.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, M_stall, M_bubble;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd, cc_zf, cc_sf, cc_of;
  logic [63:0] M_valE, M_valA;

  execute_stage #(.W(64), .REG_NONE(4'hF)) dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall),
    .M_bubble(M_bubble), .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stat, icode, dstE, dstM;
    logic        cnd, zf, sf, of;
    logic [63:0] valE, valA;
  } exp_t;

  exp_t q[$];
  exp_t mM;                       // model of M register
  logic mzf, msf, mof;            // model of CC
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model one edge, push its expectation, clock, then pop and compare.
  task automatic step();
    logic [63:0] a, b, r;
    logic [3:0]  fn;
    logic        z, s, o, c;
    exp_t        e;
    case (E_icode)
      4'h2, 4'h6:       a = E_valA;
      4'h3, 4'h4, 4'h5: a = E_valC;
      4'h8, 4'hA:       a = 64'hFFFF_FFFF_FFFF_FFF8;
      4'h9, 4'hB:       a = 64'd8;
      default:          a = 64'd0;
    endcase
    b  = (E_icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? E_valB : 64'd0;
    fn = (E_icode == 4'h6) ? E_ifun : 4'h0;
    o  = 1'b0;
    case (fn)
      4'h0: begin r = a + b; o = (a[63] ~^ b[63]) & (r[63] ^ a[63]); end
      4'h1: begin r = b - a; o = (a[63] ^ b[63]) & (r[63] ^ b[63]); end
      4'h2: r = a & b;
      4'h3: r = a ^ b;
      default: r = 64'd0;
    endcase
    z = (r == 64'd0);
    s = r[63];
    c = 1'b1;
    if (E_icode == 4'h2 || E_icode == 4'h7)
      case (E_ifun)
        4'h0: c = 1'b1;
        4'h1: c = (msf != mof) || mzf;
        4'h2: c = (msf != mof);
        4'h3: c = mzf;
        4'h4: c = !mzf;
        4'h5: c = (msf == mof);
        4'h6: c = (msf == mof) && !mzf;
        default: c = 1'b0;
      endcase
    if (rst || (!M_stall && M_bubble)) begin
      mM.stat = 4'h1; mM.icode = 4'h1; mM.cnd = 1'b0; mM.valE = 64'd0;
      mM.valA = 64'd0; mM.dstE = 4'hF; mM.dstM = 4'hF;
    end else if (!M_stall) begin
      mM.stat = E_stat; mM.icode = E_icode; mM.cnd = c; mM.valE = r;
      mM.valA = E_valA; mM.dstE = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
      mM.dstM = E_dstM;
    end
    if (rst) begin
      mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    end else if (E_icode == 4'h6 && E_ifun <= 4'h3 && m_stat == 4'h1 && W_stat == 4'h1) begin
      mzf = z; msf = s; mof = o;
    end
    e = mM; e.zf = mzf; e.sf = msf; e.of = mof;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd0, 64'd1);
    end else begin
      e = q.pop_front();
      chk("M_stat",  {60'd0, M_stat},  {60'd0, e.stat});
      chk("M_icode", {60'd0, M_icode}, {60'd0, e.icode});
      chk("M_Cnd",   {63'd0, M_Cnd},   {63'd0, e.cnd});
      chk("M_valE",  M_valE,           e.valE);
      chk("M_valA",  M_valA,           e.valA);
      chk("M_dstE",  {60'd0, M_dstE},  {60'd0, e.dstE});
      chk("M_dstM",  {60'd0, M_dstM},  {60'd0, e.dstM});
      chk("cc_zf",   {63'd0, cc_zf},   {63'd0, e.zf});
      chk("cc_sf",   {63'd0, cc_sf},   {63'd0, e.sf});
      chk("cc_of",   {63'd0, cc_of},   {63'd0, e.of});
    end
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [3:0] dm);
    E_icode = ic; E_ifun = fn; E_valC = vc; E_valA = va; E_valB = vb;
    E_dstE = de; E_dstM = dm;
    step();
  endtask

  initial begin
    mM = '{default: '0};
    mzf = 1'b1; msf = 1'b0; mof = 1'b0;
    rst = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
    E_stat = 4'h1; m_stat = 4'h1; W_stat = 4'h1;
    E_icode = 4'h1; E_ifun = 4'h0; E_valC = '0; E_valA = '0; E_valB = '0;
    E_dstE = 4'hF; E_dstM = 4'hF;

    // Reset state
    issue(4'h6, 4'h0, 0, 64'd3, 64'd4, 4'h2, 4'hF);
    issue(4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF);
    chk("rst_icode", {60'd0, M_icode}, 64'd1);
    chk("rst_zf", {63'd0, cc_zf}, 64'd1);
    rst = 1'b0;

    // ADD overflow into the sign bit
    issue(4'h6, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, 4'hF);
    chk("add_ovf_valE", M_valE, 64'h8000_0000_0000_0000);
    chk("add_ovf_flags", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);

    // SUB to zero, then equal / not-equal branches
    issue(4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h3, 4'hF);
    chk("sub_zf", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    issue(4'h7, 4'h3, 64'h40, 0, 0, 4'hF, 4'hF);
    chk("je_taken", {63'd0, M_Cnd}, 64'd1);
    issue(4'h7, 4'h4, 64'h40, 0, 0, 4'hF, 4'hF);
    chk("jne_not", {63'd0, M_Cnd}, 64'd0);

    // AND, then a downstream exception freezing CC while M still loads
    issue(4'h6, 4'h2, 0, 64'hFFFF_0000, 64'h0F0F_0F0F, 4'h4, 4'hF);
    chk("and_valE", M_valE, 64'h0F0F_0000);
    W_stat = 4'h3;
    issue(4'h6, 4'h1, 0, 64'd1, 64'd0, 4'h5, 4'hF);
    chk("exc_cc_frozen", {61'd0, cc_zf, cc_sf, cc_of}, 64'b000);
    W_stat = 4'h1;

    // cmovl not taken, stack pointer arithmetic, immediate move
    issue(4'h2, 4'h2, 0, 64'h1234, 0, 4'h3, 4'hF);
    chk("cmov_dstE", {60'd0, M_dstE}, 64'hF);
    issue(4'hA, 4'h0, 0, 64'h55, 64'h100, 4'h4, 4'hF);
    chk("push_valE", M_valE, 64'hF8);
    issue(4'h3, 4'h0, 64'hABCD, 0, 0, 4'h6, 4'hF);

    // Stall two cycles: M holds, CC still updates
    M_stall = 1'b1;
    issue(4'h6, 4'h0, 0, 64'd2, 64'd3, 4'h1, 4'hF);
    issue(4'h8, 4'h0, 64'h99, 0, 64'h300, 4'h4, 4'hF);
    chk("stall_hold", M_valE, 64'hABCD);
    M_stall = 1'b0;
    M_bubble = 1'b1;
    issue(4'h3, 4'h0, 64'h77, 0, 0, 4'h6, 4'hF);
    chk("bubble_icode", {60'd0, M_icode}, 64'd1);
    M_bubble = 1'b0;
    issue(4'h5, 4'h0, 64'h10, 64'd7, 64'h20, 4'hF, 4'h7);
    M_stall = 1'b1; M_bubble = 1'b1;
    issue(4'h3, 4'h0, 64'h88, 0, 0, 4'h6, 4'hF);
    chk("stall_over_bubble", M_valE, 64'h30);
    M_stall = 1'b0; M_bubble = 1'b0;

    // Invalid OPQ function, negative result, remaining conditions
    issue(4'h6, 4'h5, 0, 64'd9, 64'd9, 4'h2, 4'hF);
    issue(4'h6, 4'h1, 0, 64'd2, 64'd1, 4'h2, 4'hF);
    issue(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF);
    issue(4'h7, 4'h1, 0, 0, 0, 4'hF, 4'hF);
    issue(4'h2, 4'h6, 0, 64'h5A, 0, 4'h3, 4'hF);
    issue(4'h7, 4'h7, 0, 0, 0, 4'hF, 4'hF);
    issue(4'h9, 4'h0, 0, 0, 64'h200, 4'h4, 4'hF);
    issue(4'h6, 4'h3, 0, 64'hFF00, 64'h0FF0, 4'h1, 4'hF);
    E_stat = 4'h2;
    issue(4'h6, 4'h1, 0, 64'h8000_0000_0000_0000, 64'd0, 4'h1, 4'hF);
    E_stat = 4'h1;
    m_stat = 4'h4;
    issue(4'h6, 4'h0, 0, 64'd0, 64'd0, 4'h1, 4'hF);
    m_stat = 4'h1;

    // Reset mid-stream discards the instruction and restores CC
    issue(4'h6, 4'h1, 0, 64'd3, 64'd1, 4'h1, 4'hF);
    rst = 1'b1;
    issue(4'h6, 4'h1, 0, 64'd5, 64'd1, 4'h2, 4'hF);
    chk("midrst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    chk("midrst_valE", M_valE, 64'd0);
    rst = 1'b0;
    issue(4'hB, 4'h0, 0, 0, 64'h1000, 4'h4, 4'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
